// File: rtl/ccip_if_pkg.sv
// CCI-P Tx channel structures used on the AFU side of the VAI mux.
// Field layout follows the CCI-P request header definitions.
package ccip_if_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [63:0]  t_ccip_mmioData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/vai_pkg.sv
// Shared sizing for the VAI Tx path: default buffer depth, almost-full slack
// and the occupancy-counter width helper used by both the skid buffer and the mux.
package vai_pkg;

    localparam int VAI_TX_DEPTH         = 16;
    localparam int VAI_TX_ALMFULL_SLACK = 8;

    // Counter must represent 0..depth inclusive.
    function automatic int vaiCountWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vai_sync_fifo.sv
// Single-clock request FIFO with registered head output, occupancy count,
// registered threshold flag and sticky overflow. DEPTH must be a power of two.
module vai_sync_fifo
    import vai_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = VAI_TX_DEPTH,
    parameter  int THRESHOLD = VAI_TX_DEPTH - VAI_TX_ALMFULL_SLACK,
    localparam int CNT_W     = vaiCountWidth(DEPTH),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic             pClk,
    input  logic             SoftReset_n,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popStall,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    output logic [CNT_W-1:0] count,
    output logic             almFull,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             isFull;
    logic             isEmpty;
    logic             doPush;
    logic             doPop;
    logic             dropReq;
    logic [CNT_W-1:0] nextCount;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        isFull    = (count == CNT_W'(DEPTH));
        isEmpty   = (count == '0);
        doPop     = !isEmpty && !popStall;
        // A full FIFO still accepts a request when the head leaves in the same cycle.
        doPush    = pushValid && (!isFull || doPop);
        dropReq   = pushValid && !doPush;
        nextCount = count;
        if (doPush && !doPop) begin
            nextCount = count + CNT_W'(1);
        end else if (!doPush && doPop) begin
            nextCount = count - CNT_W'(1);
        end
    end

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            outValid <= 1'b0;
            almFull  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= nextCount;
            outValid <= doPop;
            // Looking at next-count raises the flag in the cycle the threshold is reached.
            almFull  <= (nextCount >= CNT_W'(THRESHOLD));
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (dropReq) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage and head payload carry no reset; validity lives in count/outValid.
    always_ff @(posedge pClk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
        if (doPop) begin
            outData <= mem[rdPtr];
        end
    end

endmodule

// File: rtl/vai_tx_skid_buf.sv
// Per-sub-AFU Tx buffer in front of vai_mux: independent c0/c1 request FIFOs
// drained under the mux almost-full, regenerated almost-full to the AFU, registered c2.
module vai_tx_skid_buf
    import ccip_if_pkg::*, vai_pkg::*;
#(
    parameter  int DEPTH         = VAI_TX_DEPTH,
    parameter  int ALMFULL_SLACK = VAI_TX_ALMFULL_SLACK,
    localparam int CNT_W         = vaiCountWidth(DEPTH)
) (
    input  logic           pClk,
    input  logic           SoftReset_n,
    input  t_if_ccip_c0_Tx afu_c0Tx,
    input  t_if_ccip_c1_Tx afu_c1Tx,
    input  t_if_ccip_c2_Tx afu_c2Tx,
    output logic           afu_c0TxAlmFull,
    output logic           afu_c1TxAlmFull,
    input  logic           up_c0TxAlmFull,
    input  logic           up_c1TxAlmFull,
    output t_if_ccip_c0_Tx up_c0Tx,
    output t_if_ccip_c1_Tx up_c1Tx,
    output t_if_ccip_c2_Tx up_c2Tx,
    output logic [CNT_W-1:0] c0_count,
    output logic [CNT_W-1:0] c1_count,
    output logic [1:0]     overflow_err
);

    localparam int C0_W      = $bits(t_ccip_c0_ReqMemHdr);
    localparam int C1_W      = $bits(t_ccip_c1_ReqMemHdr) + $bits(t_ccip_clData);
    localparam int THRESHOLD = DEPTH - ALMFULL_SLACK;

    logic            c0OutValid;
    logic [C0_W-1:0] c0OutData;
    logic            c1OutValid;
    logic [C1_W-1:0] c1OutData;

    vai_sync_fifo #(
        .WIDTH     (C0_W),
        .DEPTH     (DEPTH),
        .THRESHOLD (THRESHOLD)
    ) c0Fifo (
        .pClk        (pClk),
        .SoftReset_n (SoftReset_n),
        .pushValid   (afu_c0Tx.valid),
        .pushData    (afu_c0Tx.hdr),
        .popStall    (up_c0TxAlmFull),
        .outValid    (c0OutValid),
        .outData     (c0OutData),
        .count       (c0_count),
        .almFull     (afu_c0TxAlmFull),
        .overflow    (overflow_err[0])
    );

    vai_sync_fifo #(
        .WIDTH     (C1_W),
        .DEPTH     (DEPTH),
        .THRESHOLD (THRESHOLD)
    ) c1Fifo (
        .pClk        (pClk),
        .SoftReset_n (SoftReset_n),
        .pushValid   (afu_c1Tx.valid),
        .pushData    ({afu_c1Tx.hdr, afu_c1Tx.data}),
        .popStall    (up_c1TxAlmFull),
        .outValid    (c1OutValid),
        .outData     (c1OutData),
        .count       (c1_count),
        .almFull     (afu_c1TxAlmFull),
        .overflow    (overflow_err[1])
    );

    // FIFO words are laid out in struct field order, so unpacking is a concatenation.
    always_comb begin
        up_c0Tx = {c0OutData, c0OutValid};
        up_c1Tx = {c1OutData, c1OutValid};
    end

    // MMIO responses are never back-pressured; a single register stage suffices.
    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            up_c2Tx <= '0;
        end else begin
            up_c2Tx <= afu_c2Tx;
        end
    end

endmodule

// File: doc/vai_tx_skid_buf.md
# vai_tx_skid_buf

Per-sub-AFU Tx request buffer between each sub-AFU's CCI-P Tx port and the corresponding `afu_TxPort[i]` input of `vai_mux`, one instance per sub-AFU. It buffers c0 (read) and c1 (write) requests in independent FIFOs and drains them only while the mux-side almost-full is low. It regenerates a conservative almost-full toward the AFU, so the CCI-P rule of up to ALMFULL_SLACK further requests after almost-full never overflows. c2 (MMIO read response) is registered and passed straight through.

## Interface
Parameters:
- DEPTH, 16, entries per channel FIFO (power of two, ≥ 2·ALMFULL_SLACK)
- ALMFULL_SLACK, 8, requests an AFU may still issue after seeing almost-full

Ports:
- pClk  in  1  sole clock
- SoftReset_n  in  1  asynchronous, active-low reset
- afu_c0Tx  in  t_if_ccip_c0_Tx  read request from AFU (valid + hdr)
- afu_c1Tx  in  t_if_ccip_c1_Tx  write request from AFU (valid + hdr + data)
- afu_c2Tx  in  t_if_ccip_c2_Tx  MMIO read response from AFU
- afu_c0TxAlmFull  out  1  almost-full to AFU, c0
- afu_c1TxAlmFull  out  1  almost-full to AFU, c1
- up_c0TxAlmFull  in  1  almost-full from mux, c0
- up_c1TxAlmFull  in  1  almost-full from mux, c1
- up_c0Tx  out  t_if_ccip_c0_Tx  read request to mux
- up_c1Tx  out  t_if_ccip_c1_Tx  write request to mux
- up_c2Tx  out  t_if_ccip_c2_Tx  MMIO response to mux
- c0_count, c1_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow_err  out  2  sticky push-while-full flag, [0]=c0, [1]=c1

## Operation
- Reset (SoftReset_n low, async): both FIFOs empty, counts 0, all up_* valid bits 0, afu_c*TxAlmFull 0, overflow_err 0. Payload fields don't-care.
- Push per channel: afu_cXTx.valid high → enqueue at the clock edge if count < DEPTH, or if count == DEPTH and a pop happens in the same cycle.
- Overflow: push with count == DEPTH and no pop → request dropped, overflow_err[X] set until reset. Occupancy is unchanged.
- Pop per channel: count > 0 and up_cXTxAlmFull low → dequeue the head. up_cXTx is registered: payload driven and valid = 1 for exactly the cycle after the pop decision. Otherwise valid = 0 and payload holds its last value.
- Simultaneous push and pop → count unchanged; ordering is preserved.
- Strict FIFO order within a channel. No ordering is enforced between c0 and c1.
- Almost-full out: afu_cXTxAlmFull is registered from next-count ≥ DEPTH − ALMFULL_SLACK. It is therefore high in the same cycle the count first reaches the threshold, which guarantees room for ALMFULL_SLACK more pushes.
- c2: up_c2Tx is registered from afu_c2Tx every cycle. It is never stalled and never buffered.
- Reset asserted mid-operation: queued requests are discarded without being emitted. No partial valid appears on up_* after reset release.

## Timing
- Minimum c0/c1 latency is 2 cycles: a push at edge k makes the count nonzero at k+1; a pop is decided in cycle k+1; up valid appears after edge k+2.
- Steady-state throughput is 1 request/cycle/channel while up almost-full is low.
- Pop is gated by up_cXTxAlmFull sampled in the same cycle. A rising up almost-full stops the next pop; the request already registered still emits.
- c2 latency is 1 cycle.
- Occupancy wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided from the count, not from pointer equality.

## Structure
- t_if_ccip_c0_Tx, t_if_ccip_c1_Tx and t_if_ccip_c2_Tx come from ccip_if_pkg.
- The DEPTH/ALMFULL_SLACK defaults and the count-width function go in vai_pkg, shared with vai_mux.
- One sub-module, vai_sync_fifo (parameterised by width, depth and threshold, registered output, count, full flag, overflow flag), instantiated twice: c0 with header width, c1 with header+data width.
- The top level adds the c2 register and the struct pack/unpack.

## Test plan
- Single c0 read, up_c0TxAlmFull low: push at cycle 0 → up_c0Tx.valid high at cycle 2 with an identical header; c0_count goes 0→1→0.
- Burst of 8 c1 writes back-to-back, DEPTH=16, SLACK=8, up_c1TxAlmFull held high: afu_c1TxAlmFull high from the cycle count reaches 8. Issue 8 more writes → count 16, overflow_err = 0. A 17th write → dropped, overflow_err[1] = 1.
- Release up_c1TxAlmFull with 16 queued writes: 16 consecutive valid cycles in push order (check data tags 0..15); afu_c1TxAlmFull drops the cycle count goes below 8.
- Full FIFO (count 16) with simultaneous push and pop: count stays 16, no overflow, and the new entry emerges last.
- Toggle up_c0TxAlmFull every cycle during a 10-read burst: exactly 10 valid outputs, in order, none on cycles after almost-full was high.
- Assert SoftReset_n low with 5 entries queued and a c2 response in flight: all up_* valid bits drop immediately. After release, counts are 0 and no stale request is emitted.
